boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader_ctrl
//  Description : UART boot loader. Waits for a 0xFF sync byte, checks a
//                32-bit magic word, reads a 32-bit program length and then
//                streams that many 32-bit words (MSB first) into instruction
//                memory. The CPU is held in reset until the whole program
//                has been written.
//
//  Ports
//    clock      : rising-edge clock
//    reset      : asynchronous active-high reset
//    rx_valid   : one-cycle strobe, one received byte
//    rx_data    : received byte, valid with rx_valid
//    reload     : restart loading (only acted on in DONE)
//    mem_we     : one-cycle instruction-memory write strobe
//    mem_addr   : word address of the write
//    mem_wdata  : assembled instruction word (held between writes)
//    cpu_reset  : holds the core in reset while high
//    done       : program fully loaded
//    err_code   : sticky error: 00 none, 01 magic, 10 length, 11 timeout
//
//  Revision    : 1.0  initial release
// ============================================================================
module boot_loader_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter int          MAX_WORDS = 4096,
    parameter logic [31:0] MAGIC     = 32'h43414645,
    parameter int          TIMEOUT   = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic [1:0]        err_code
);

    // The gap counter only ever needs to hold 0 .. TIMEOUT-1.
    localparam int                c_GAP_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [ADDR_W:0]    c_ADDR_ONE = (ADDR_W + 1)'(1);
    localparam logic [7:0]         c_SYNC_BYTE = 8'hFF;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_MAGIC   = 2'b01;
    localparam logic [1:0] c_ERR_LEN     = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_MAGIC = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [31:0]         r_shift;
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W:0]     r_word_cnt;
    logic [ADDR_W:0]     r_addr;
    logic [c_GAP_W-1:0]  r_gap;
    logic                r_mem_we;
    logic [31:0]         r_mem_wdata;
    logic                r_cpu_reset;
    logic                r_done;
    logic [1:0]          r_err_code;

    logic                w_loading;
    logic                w_take_byte;
    logic                w_word_done;
    logic [31:0]         w_word;
    logic                w_magic_ok;
    logic                w_len_bad;
    logic                w_timeout;
    logic                w_last_write;

    // ------------------------------------------------------------------
    // Decode of the current cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_loading    = (r_state == S_MAGIC) || (r_state == S_LEN) || (r_state == S_DATA);
        w_take_byte  = rx_valid && w_loading;
        w_word_done  = w_take_byte && (r_byte_cnt == 2'd3);
        w_word       = {r_shift[23:0], rx_data};
        w_magic_ok   = (w_word == MAGIC);
        w_len_bad    = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));
        // A byte arriving in the expiry cycle wins over the timeout.
        w_timeout    = w_loading && !rx_valid && (r_gap == c_GAP_LAST);
        // r_addr still holds the address being written during the mem_we cycle.
        w_last_write = (r_state == S_DATA) && r_mem_we &&
                       ((r_addr + c_ADDR_ONE) == r_word_cnt);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_SYNC: begin
                if (rx_valid && (rx_data == c_SYNC_BYTE)) begin
                    w_next_state = S_MAGIC;
                end
            end
            S_MAGIC: begin
                if (w_word_done) begin
                    w_next_state = w_magic_ok ? S_LEN : S_SYNC;
                end
            end
            S_LEN: begin
                if (w_word_done) begin
                    w_next_state = w_len_bad ? S_SYNC : S_DATA;
                end
            end
            S_DATA: begin
                // Stay in DATA through the final write so that cpu_reset
                // and done change only in the cycle after that mem_we.
                if (w_last_write) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (reload) begin
                    w_next_state = S_SYNC;
                end
            end
            default: w_next_state = S_SYNC;
        endcase
        if (w_timeout) begin
            w_next_state = S_SYNC;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift     <= 32'd0;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= '0;
            r_addr      <= '0;
            r_gap       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_mem_we    <= 1'b0;
            r_cpu_reset <= (w_next_state != S_DONE);
            r_done      <= (w_next_state == S_DONE);

            if (rx_valid || !w_loading || w_timeout) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + c_GAP_ONE;
            end

            if (w_take_byte) begin
                r_shift    <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if (r_mem_we) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end

            case (r_state)
                S_MAGIC: begin
                    if (w_word_done) begin
                        r_err_code <= w_magic_ok ? c_ERR_NONE : c_ERR_MAGIC;
                    end
                end
                S_LEN: begin
                    if (w_word_done) begin
                        if (w_len_bad) begin
                            r_err_code <= c_ERR_LEN;
                        end else begin
                            r_word_cnt <= w_word[ADDR_W:0];
                            r_addr     <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_done) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        r_addr     <= '0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                default: begin
                end
            endcase

            // Already-written words stay in memory; only the pointers reset.
            if (w_timeout) begin
                r_err_code <= c_ERR_TIMEOUT;
                r_byte_cnt <= 2'd0;
                r_addr     <= '0;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr[ADDR_W-1:0];
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_boot_loader_ctrl
//  Description : Directed self-checking bench for boot_loader_ctrl. Bytes are
//                driven on the falling edge, outputs sampled on falling edges.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_boot_loader_ctrl;

    localparam int          ADDR_W    = 4;
    localparam int          MAX_WORDS = 16;
    localparam int          TIMEOUT   = 40;
    localparam logic [31:0] MAGIC     = 32'h43414645;

    logic              clock = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic [1:0]        err_code;

    int n_total = 0;
    int n_bad   = 0;
    int wr_cnt  = 0;

    logic [31:0] mem_model [0:15];
    logic [31:0] prog [0:7] = '{32'h00000013, 32'h20000137, 32'h02010113, 32'h00800193,
                                32'h00012223, 32'h00012023, 32'h00312023, 32'hff9ff06f};

    boot_loader_ctrl #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .MAGIC     (MAGIC),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    // Memory model: records what the loader wrote (values before the edge).
    always @(posedge clock) begin
        if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 3; i >= 0; i--) send_byte(tmp[i*8 +: 8]);
    endtask

    task automatic send_header(input logic [31:0] len);
        send_byte(8'hFF);
        send_word(MAGIC);
        send_word(len);
    endtask

    // Sends one data word and checks the write strobe it produces.
    task automatic send_data(input logic [31:0] w, input int idx);
        send_word(w);
        chk($sformatf("we_%0d", idx), {31'd0, mem_we}, 32'd1);
        chk($sformatf("addr_%0d", idx), {28'd0, mem_addr}, 32'(idx));
        chk($sformatf("wdata_%0d", idx), mem_wdata, w);
    endtask

    task automatic do_reload();
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reload_done", {31'd0, done}, 32'd0);
        chk("reload_addr", {28'd0, mem_addr}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"},  {28'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_err"},   {30'd0, err_code}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        #12;
        chk_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;

        // Nominal 8-word load
        send_header(32'd8);
        for (int i = 0; i < 8; i++) send_data(prog[i], i);
        chk("nom_done_early", {31'd0, done}, 32'd0);
        chk("nom_cpurst_early", {31'd0, cpu_reset}, 32'd1);
        @(negedge clock);
        chk("nom_done", {31'd0, done}, 32'd1);
        chk("nom_cpurst", {31'd0, cpu_reset}, 32'd0);
        chk("nom_we_off", {31'd0, mem_we}, 32'd0);
        chk("nom_wdata_hold", mem_wdata, prog[7]);
        chk("nom_err", {30'd0, err_code}, 32'd0);
        chk("nom_wrcnt", 32'(wr_cnt), 32'd8);

        // Bytes in DONE are ignored
        send_byte(8'hFF);
        send_word(32'h12345678);
        @(negedge clock);
        chk("done_ign_wr", 32'(wr_cnt), 32'd8);
        chk("done_ign_done", {31'd0, done}, 32'd1);
        do_reload();

        // Leading junk bytes before sync
        wr_cnt = 0;
        send_byte(8'h00);
        send_byte(8'h7A);
        send_header(32'd8);
        for (int i = 0; i < 8; i++) send_data(prog[i], i);
        @(negedge clock);
        chk("lead_done", {31'd0, done}, 32'd1);
        chk("lead_wrcnt", 32'(wr_cnt), 32'd8);
        chk("lead_mem5", mem_model[5], prog[5]);
        do_reload();

        // Bad magic, then a good load clears the error
        wr_cnt = 0;
        send_byte(8'hFF);
        send_word(32'h43414646);
        @(negedge clock);
        chk("bmag_err", {30'd0, err_code}, 32'd1);
        chk("bmag_wr", 32'(wr_cnt), 32'd0);
        chk("bmag_cpurst", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'hFF);
        send_word(MAGIC);
        chk("bmag_clr", {30'd0, err_code}, 32'd0);
        send_word(32'd2);
        send_data(prog[0], 0);
        send_data(prog[1], 1);
        @(negedge clock);
        chk("bmag_done", {31'd0, done}, 32'd1);
        do_reload();

        // Bad lengths: 0 and MAX_WORDS+1
        wr_cnt = 0;
        send_header(32'd0);
        chk("len0_err", {30'd0, err_code}, 32'd2);
        send_byte(8'hFF);
        send_word(MAGIC);
        chk("len_mag_clr", {30'd0, err_code}, 32'd0);
        send_word(32'(MAX_WORDS + 1));
        @(negedge clock);
        chk("lenmax_err", {30'd0, err_code}, 32'd2);
        chk("len_wr", 32'(wr_cnt), 32'd0);
        chk("len_cpurst", {31'd0, cpu_reset}, 32'd1);

        // Timeout after 3 bytes of the second word
        wr_cnt = 0;
        send_header(32'd4);
        send_data(prog[0], 0);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (TIMEOUT - 1) @(negedge clock);
        chk("to_early_err", {30'd0, err_code}, 32'd0);
        @(negedge clock);
        chk("to_err", {30'd0, err_code}, 32'd3);
        chk("to_addr", {28'd0, mem_addr}, 32'd0);
        repeat (10) @(negedge clock);
        chk("to_wrcnt", 32'(wr_cnt), 32'd1);
        chk("to_mem0", mem_model[0], prog[0]);
        // Fresh load must realign at address 0 from a cleared byte counter
        send_header(32'd1);
        send_data(prog[2], 0);
        @(negedge clock);
        chk("to_reload_done", {31'd0, done}, 32'd1);
        do_reload();

        // Asynchronous reset between words 4 and 5
        wr_cnt = 0;
        send_header(32'd8);
        for (int i = 0; i < 4; i++) send_data(prog[i], i);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_mid");
        @(negedge clock);
        reset = 1'b0;
        send_word(prog[4]);
        send_word(prog[5]);
        @(negedge clock);
        chk("rst_mid_wr", 32'(wr_cnt), 32'd4);
        chk("rst_mid_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("rst_mid_addr", {28'd0, mem_addr}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
